// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: three requesters share one register-file write port, registered output (1 cycle).
// Optional forwarding taps enabled by defining WB_FWD_EN.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            req_valid,
    output logic [2:0]            req_ready,
    input  logic [3*ADDR_W-1:0]   req_reg,
    input  logic [3*DATA_W-1:0]   req_data,
    input  logic                  rf_busy,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [15:0]           wb_count
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]     fwd_raddr_a,
    input  logic [ADDR_W-1:0]     fwd_raddr_b,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    logic [1:0]        last_q, last_d;
    logic [1:0]        start;
    logic [1:0]        gnt_idx;
    logic              xfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       cnt_q, cnt_d;

    always_comb begin
        case (last_q)
            2'd0:    start = 2'd1;
            2'd1:    start = 2'd2;
            default: start = 2'd0;
        endcase
    end

    // First valid requester at or after the start position, wrapping 2 -> 0.
    always_comb begin
        gnt_idx = 2'd0;
        case (start)
            2'd1: begin
                if (req_valid[1])      gnt_idx = 2'd1;
                else if (req_valid[2]) gnt_idx = 2'd2;
                else                   gnt_idx = 2'd0;
            end
            2'd2: begin
                if (req_valid[2])      gnt_idx = 2'd2;
                else if (req_valid[0]) gnt_idx = 2'd0;
                else                   gnt_idx = 2'd1;
            end
            default: begin
                if (req_valid[0])      gnt_idx = 2'd0;
                else if (req_valid[1]) gnt_idx = 2'd1;
                else                   gnt_idx = 2'd2;
            end
        endcase
    end

    always_comb begin
        req_ready = 3'b000;
        if (rst_n && !rf_busy && !flush && (|req_valid)) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    always_comb begin
        case (gnt_idx)
            2'd1: begin
                sel_reg  = req_reg[ADDR_W +: ADDR_W];
                sel_data = req_data[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_reg  = req_reg[2*ADDR_W +: ADDR_W];
                sel_data = req_data[2*DATA_W +: DATA_W];
            end
            default: begin
                sel_reg  = req_reg[0 +: ADDR_W];
                sel_data = req_data[0 +: DATA_W];
            end
        endcase
    end

    // Writes to register 0 complete the handshake but never raise the write enable.
    always_comb begin
        last_d  = xfer ? gnt_idx : last_q;
        we_d    = xfer && (sel_reg != '0);
        waddr_d = xfer ? sel_reg : waddr_q;
        wdata_d = xfer ? sel_data : wdata_q;
        cnt_d   = (we_q && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 2'd2;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= 16'd0;
        end else begin
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign wb_count = cnt_q;

`ifdef WB_FWD_EN
    assign fwd_hit_a = we_q && (waddr_q == fwd_raddr_a) && (fwd_raddr_a != '0);
    assign fwd_hit_b = we_q && (waddr_q == fwd_raddr_b) && (fwd_raddr_b != '0);
    assign fwd_data  = wdata_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter: table of per-cycle stimulus with expected grant and write-back outputs.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic        rf_busy;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] wb_count;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_raddr_a;
    logic [4:0]  fwd_raddr_b;
    logic        fwd_hit_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data;
`endif

    wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .rf_busy   (rf_busy),
        .flush     (flush),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_count  (wb_count)
`ifdef WB_FWD_EN
        ,
        .fwd_raddr_a (fwd_raddr_a),
        .fwd_raddr_b (fwd_raddr_b),
        .fwd_hit_a   (fwd_hit_a),
        .fwd_hit_b   (fwd_hit_b),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic        busy;
        logic        fl;
        logic [4:0]  r0, r1, r2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[19];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [2:0] v, input logic busy, input logic fl,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] rdy, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [15:0] cnt);
        vec_t t;
        t.v = v; t.busy = busy; t.fl = fl;
        t.r0 = r0; t.r1 = r1; t.r2 = r2;
        t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
        req_valid = v;
        req_reg   = {r2, r1, r0};
        req_data  = {d2, d1, d0};
    endtask

    initial begin
        // rdy checks this cycle's grant; we/wa/wd/cnt reflect the previous cycle.
        vecs[0]  = mk(3'b111, 0, 0, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001, 0, 0, 32'h0, 0);
        vecs[1]  = mk(3'b111, 0, 0, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b010, 1, 1, 32'h11111111, 0);
        vecs[2]  = mk(3'b111, 0, 0, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b100, 1, 2, 32'h22222222, 1);
        vecs[3]  = mk(3'b111, 0, 0, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001, 1, 3, 32'h33333333, 2);
        vecs[4]  = mk(3'b111, 0, 0, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b010, 1, 1, 32'h11111111, 3);
        vecs[5]  = mk(3'b111, 0, 0, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b100, 1, 2, 32'h22222222, 4);
        vecs[6]  = mk(3'b101, 1, 0, 4, 2, 6, 32'h44444444, 32'h22222222, 32'h66666666, 3'b000, 1, 3, 32'h33333333, 5);
        vecs[7]  = mk(3'b101, 1, 0, 4, 2, 6, 32'h44444444, 32'h22222222, 32'h66666666, 3'b000, 0, 3, 32'h33333333, 6);
        vecs[8]  = mk(3'b101, 1, 0, 4, 2, 6, 32'h44444444, 32'h22222222, 32'h66666666, 3'b000, 0, 3, 32'h33333333, 6);
        vecs[9]  = mk(3'b101, 0, 0, 4, 2, 6, 32'h44444444, 32'h22222222, 32'h66666666, 3'b001, 0, 3, 32'h33333333, 6);
        vecs[10] = mk(3'b100, 0, 0, 4, 2, 6, 32'h44444444, 32'h22222222, 32'h66666666, 3'b100, 1, 4, 32'h44444444, 6);
        vecs[11] = mk(3'b010, 0, 0, 4, 0, 6, 32'h44444444, 32'hDEADBEEF, 32'h66666666, 3'b010, 1, 6, 32'h66666666, 7);
        vecs[12] = mk(3'b001, 0, 1, 9, 0, 6, 32'h99999999, 32'hDEADBEEF, 32'h66666666, 3'b000, 0, 0, 32'hDEADBEEF, 8);
        vecs[13] = mk(3'b001, 0, 0, 9, 0, 6, 32'h99999999, 32'hDEADBEEF, 32'h66666666, 3'b001, 0, 0, 32'hDEADBEEF, 8);
        vecs[14] = mk(3'b000, 0, 0, 9, 0, 6, 32'h99999999, 32'hDEADBEEF, 32'h66666666, 3'b000, 1, 9, 32'h99999999, 8);
        vecs[15] = mk(3'b000, 0, 0, 9, 0, 6, 32'h99999999, 32'hDEADBEEF, 32'h66666666, 3'b000, 0, 9, 32'h99999999, 9);
        vecs[16] = mk(3'b011, 0, 0, 9, 5, 6, 32'h99999999, 32'h55555555, 32'h66666666, 3'b010, 0, 9, 32'h99999999, 9);
        vecs[17] = mk(3'b011, 0, 0, 8, 5, 6, 32'h88888888, 32'h55555555, 32'h66666666, 3'b001, 1, 5, 32'h55555555, 9);
        vecs[18] = mk(3'b000, 0, 0, 8, 5, 6, 32'h88888888, 32'h55555555, 32'h66666666, 3'b000, 1, 8, 32'h88888888, 10);

        rst_n   = 1'b0;
        rf_busy = 1'b0;
        flush   = 1'b0;
        drive(3'b111, 1, 2, 3, 32'h11111111, 32'h22222222, 32'h33333333);
`ifdef WB_FWD_EN
        fwd_raddr_a = 5'd0;
        fwd_raddr_b = 5'd0;
`endif
        #3;
        chk("reset req_ready", {29'd0, req_ready}, 32'd0);
        chk("reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset wb_count", {16'd0, wb_count}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drive(vecs[i].v, vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            rf_busy = vecs[i].busy;
            flush   = vecs[i].fl;
            #1;
            chk($sformatf("v%0d req_ready", i), {29'd0, req_ready}, {29'd0, vecs[i].rdy});
            chk($sformatf("v%0d rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].wa});
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].wd);
            chk($sformatf("v%0d wb_count", i), {16'd0, wb_count}, {16'd0, vecs[i].cnt});
        end

        // Reset dropped mid-cycle while reg 7 is being granted.
        @(negedge clk);
        drive(3'b001, 7, 0, 0, 32'h12345678, 32'h0, 32'h0);
        #1;
        chk("pre-reset grant", {29'd0, req_ready}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-reset req_ready", {29'd0, req_ready}, 32'd0);
        chk("mid-reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("mid-reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("mid-reset rf_wdata", rf_wdata, 32'd0);
        chk("mid-reset wb_count", {16'd0, wb_count}, 32'd0);
        @(negedge clk);
        drive(3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset rf_we", {31'd0, rf_we}, 32'd0);
        chk("post-reset rf_waddr", {27'd0, rf_waddr}, 32'd0);

`ifdef WB_FWD_EN
        @(negedge clk);
        drive(3'b001, 5, 0, 0, 32'hA5A5A5A5, 32'h0, 32'h0);
        fwd_raddr_a = 5'd5;
        fwd_raddr_b = 5'd0;
        @(negedge clk);
        drive(3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("fwd_hit_a", {31'd0, fwd_hit_a}, 32'd1);
        chk("fwd_hit_b", {31'd0, fwd_hit_b}, 32'd0);
        chk("fwd_data", fwd_data, 32'hA5A5A5A5);
        @(negedge clk);
        #1;
        chk("fwd_hit_a idle", {31'd0, fwd_hit_a}, 32'd0);
`endif

        // Saturation: more than 65535 back-to-back writes.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(3'b001, 1, 0, 0, 32'h1, 32'h0, 32'h0);
        for (int c = 0; c < 65540; c++) @(negedge clk);
        drive(3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("wb_count saturated", {16'd0, wb_count}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
